// File: rtl/logic_capture_axi_bridge.sv
// ---------------------------------------------------------------------------
// logic_capture_axi_bridge
//
// Turns the capture core's request interface into AXI4 master traffic.
// Each request is one entry in a small FIFO. A read entry issues one AR.
// A write burst is one entry per beat. The first beat of a burst drives AW
// and W together, and each later beat drives W only. B responses are
// returned through one ack port, and so are R responses (last beat only).
// A sticky error flag and idle/outstanding status are provided for the
// capture controller's flush logic.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   inport_*                 capture-side request / response interface
//   error_clr_i, error_o     sticky response error and its clear
//   idle_o, outstanding_o    flush status
//   outport_aw*/w*/b*        AXI4 write address / data / response
//   outport_ar*/r*           AXI4 read address / data
// ---------------------------------------------------------------------------
module logic_capture_axi_bridge #(
    parameter int unsigned AXI_ID          = 0,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned REQ_DEPTH       = 8,
    parameter int unsigned REQ_ADDR_W      = 3,
    parameter int unsigned MAX_OUTSTANDING = 16,
    localparam int unsigned STRB_W         = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic [STRB_W-1:0] inport_wr_i,
    input  logic              inport_rd_i,
    input  logic [7:0]        inport_len_i,
    input  logic [31:0]       inport_addr_i,
    input  logic [DATA_W-1:0] inport_write_data_i,
    output logic              inport_accept_o,
    output logic              inport_ack_o,
    output logic              inport_error_o,
    output logic [DATA_W-1:0] inport_read_data_o,

    input  logic              error_clr_i,
    output logic              error_o,
    output logic              idle_o,
    output logic [7:0]        outstanding_o,

    output logic              outport_awvalid_o,
    input  logic              outport_awready_i,
    output logic [31:0]       outport_awaddr_o,
    output logic [3:0]        outport_awid_o,
    output logic [7:0]        outport_awlen_o,
    output logic [1:0]        outport_awburst_o,
    output logic              outport_wvalid_o,
    input  logic              outport_wready_i,
    output logic [DATA_W-1:0] outport_wdata_o,
    output logic [STRB_W-1:0] outport_wstrb_o,
    output logic              outport_wlast_o,
    input  logic              outport_bvalid_i,
    output logic              outport_bready_o,
    input  logic [1:0]        outport_bresp_i,
    input  logic [3:0]        outport_bid_i,
    output logic              outport_arvalid_o,
    input  logic              outport_arready_i,
    output logic [31:0]       outport_araddr_o,
    output logic [3:0]        outport_arid_o,
    output logic [7:0]        outport_arlen_o,
    output logic [1:0]        outport_arburst_o,
    input  logic              outport_rvalid_i,
    output logic              outport_rready_o,
    input  logic [DATA_W-1:0] outport_rdata_i,
    input  logic [1:0]        outport_rresp_i,
    input  logic [3:0]        outport_rid_i,
    input  logic              outport_rlast_i
);

    localparam int unsigned        OFF_W   = (DATA_W == 64) ? 3 : 2;
    localparam logic [7:0]         MAX_OUT = 8'(MAX_OUTSTANDING);
    localparam logic [REQ_ADDR_W:0] DEPTH  = (REQ_ADDR_W + 1)'(REQ_DEPTH);

    // Request FIFO storage. Only the pointers and count are reset.
    logic              fifo_rd_q   [REQ_DEPTH];
    logic [STRB_W-1:0] fifo_strb_q [REQ_DEPTH];
    logic [7:0]        fifo_len_q  [REQ_DEPTH];
    logic [31:0]       fifo_addr_q [REQ_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [REQ_DEPTH];

    logic [REQ_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [REQ_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [REQ_ADDR_W:0]   count_q, count_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [7:0]            outstanding_q, outstanding_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  error_q, error_d;

    logic              push, pop;
    logic              head_valid, head_rd;
    logic [STRB_W-1:0] head_strb;
    logic [7:0]        head_len;
    logic [31:0]       head_addr, bus_addr;
    logic [DATA_W-1:0] head_data;
    logic              first_beat, can_issue;
    logic              rd_issue, wr_first, wr_later;
    logic              aw_hs, w_hs, ar_hs;
    logic              b_ack, r_ack, ack, resp_err;
    logic              unused_inputs;

    assign push       = (inport_rd_i | (|inport_wr_i)) & inport_accept_o;
    assign head_valid = (count_q != '0);
    assign head_rd    = fifo_rd_q[rd_ptr_q];
    assign head_strb  = fifo_strb_q[rd_ptr_q];
    assign head_len   = fifo_len_q[rd_ptr_q];
    assign head_addr  = fifo_addr_q[rd_ptr_q];
    assign head_data  = fifo_data_q[rd_ptr_q];
    assign bus_addr   = {head_addr[31:OFF_W], {OFF_W{1'b0}}};

    assign first_beat = (beat_cnt_q == 8'd0);
    // A later beat, or a first beat whose AW has already been accepted,
    // owns a response slot already, so the outstanding limit does not
    // gate it. Without the aw_done_q term, wvalid could drop mid-handshake.
    assign can_issue  = (outstanding_q < MAX_OUT) | ~first_beat | aw_done_q;
    assign rd_issue   = head_valid & first_beat & head_rd & can_issue;
    assign wr_first   = head_valid & first_beat & ~head_rd & can_issue;
    assign wr_later   = head_valid & ~first_beat;

    assign outport_awvalid_o = wr_first & ~aw_done_q;
    assign outport_wvalid_o  = (wr_first & ~w_done_q) | wr_later;
    assign outport_arvalid_o = rd_issue;

    assign aw_hs = outport_awvalid_o & outport_awready_i;
    assign w_hs  = outport_wvalid_o & outport_wready_i;
    assign ar_hs = outport_arvalid_o & outport_arready_i;

    // A first write beat leaves the FIFO only once AW and W have both
    // completed, whether in the same cycle or in different cycles.
    assign pop = ar_hs
               | (wr_first & (aw_done_q | aw_hs) & (w_done_q | w_hs))
               | (wr_later & w_hs);

    assign outport_awaddr_o  = bus_addr;
    assign outport_awid_o    = 4'(AXI_ID);
    assign outport_awlen_o   = head_len;
    assign outport_awburst_o = 2'b01;
    assign outport_wdata_o   = head_data;
    assign outport_wstrb_o   = head_strb;
    assign outport_wlast_o   = (beat_cnt_q == 8'd1) | (first_beat & (head_len == 8'd0));
    assign outport_araddr_o  = bus_addr;
    assign outport_arid_o    = 4'(AXI_ID);
    assign outport_arlen_o   = head_len;
    assign outport_arburst_o = 2'b01;

    // R has priority over B. Only the last R beat produces an ack.
    assign outport_rready_o  = 1'b1;
    assign outport_bready_o  = ~outport_rvalid_i;
    assign b_ack    = outport_bvalid_i & outport_bready_o;
    assign r_ack    = outport_rvalid_i & outport_rlast_i;
    assign ack      = b_ack | r_ack;
    assign resp_err = r_ack ? (outport_rresp_i != 2'b00) : (outport_bresp_i != 2'b00);

    assign inport_accept_o    = (count_q != DEPTH);
    assign inport_ack_o       = ack;
    assign inport_error_o     = ack & resp_err;
    assign inport_read_data_o = outport_rdata_i;
    assign error_o            = error_q;
    assign outstanding_o      = outstanding_q;
    assign idle_o             = ~head_valid & (outstanding_q == 8'd0) & first_beat
                              & ~aw_done_q & ~w_done_q;

    assign unused_inputs = ^{outport_bid_i, outport_rid_i, head_addr[OFF_W-1:0]};

    always_comb begin
        wr_ptr_d      = push ? wr_ptr_q + REQ_ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + REQ_ADDR_W'(1) : rd_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        beat_cnt_d    = beat_cnt_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        error_d       = error_q;

        unique case ({push, pop})
            2'b10:   count_d = count_q + (REQ_ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (REQ_ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        // An ack while nothing is outstanding is ignored, and the count
        // never goes past the limit.
        unique case ({ar_hs | aw_hs, ack & (outstanding_q != 8'd0)})
            2'b10: if (outstanding_q < MAX_OUT) outstanding_d = outstanding_q + 8'd1;
            2'b01: outstanding_d = outstanding_q - 8'd1;
            default: outstanding_d = outstanding_q;
        endcase

        if (pop & wr_first) begin
            beat_cnt_d = head_len;
        end else if (pop & wr_later) begin
            beat_cnt_d = beat_cnt_q - 8'd1;
        end

        if (pop & wr_first) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end else begin
            if (aw_hs) aw_done_d = 1'b1;
            if (w_hs & wr_first) w_done_d = 1'b1;
        end

        if (ack & resp_err) begin
            error_d = 1'b1;
        end else if (error_clr_i) begin
            error_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= 8'd0;
            beat_cnt_q    <= 8'd0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            beat_cnt_q    <= beat_cnt_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            error_q       <= error_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= inport_rd_i;
            fifo_strb_q[wr_ptr_q] <= inport_wr_i;
            fifo_len_q[wr_ptr_q]  <= inport_len_i;
            fifo_addr_q[wr_ptr_q] <= inport_addr_i;
            fifo_data_q[wr_ptr_q] <= inport_write_data_i;
        end
    end

endmodule
